// File: rtl/axi_master_arbiter_w.sv
// Two-master AXI write-path arbiter: holds a one-hot grant from AW through WLAST to B, round-robin on ties.
// Define AXI_ARB_FIXED_PRIO_EN to make master 0 win every tie instead of alternating.
module axi_master_arbiter_w #(
   parameter int LEN_BITS = 8
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                m0_AWVALID,
   input  logic                m1_AWVALID,
   input  logic                awvalid,
   input  logic                awready,
   input  logic [LEN_BITS-1:0] awlen,
   input  logic                wvalid,
   input  logic                wready,
   input  logic                wlast,
   input  logic                bvalid,
   input  logic                bready,
   output logic                m0_wgrnt,
   output logic                m1_wgrnt,
   output logic                wr_busy,
   output logic                wr_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [LEN_BITS:0] CNT_ONE = {{LEN_BITS{1'b0}}, 1'b1};
   localparam logic [LEN_BITS:0] CNT_MAX = '1;

   state_t              state;
   logic                last_grnt;
   logic [LEN_BITS:0]   beat_cnt;
   logic [LEN_BITS-1:0] len_q;
   logic                aw_done;
   logic                w_done;

   logic                aw_hs;
   logic                w_hs;
   logic                aw_set;
   logic                w_set;
   logic                pick_m1;
   logic                b_hs;
   logic [LEN_BITS:0]   cnt_next;
   logic [LEN_BITS:0]   exp_beats;

   // Handshakes only count once per transaction; repeats after the flag is set are ignored.
   always_comb begin
      aw_hs     = awvalid & awready & ~aw_done;
      w_hs      = wvalid & wready & ~w_done;
      aw_set    = aw_done | aw_hs;
      w_set     = w_done | (w_hs & wlast);
      b_hs      = bvalid & bready;
      cnt_next  = beat_cnt;
      if (w_hs && (beat_cnt != CNT_MAX)) begin
         cnt_next = beat_cnt + CNT_ONE;
      end
      exp_beats = aw_done ? ({1'b0, len_q} + CNT_ONE) : ({1'b0, awlen} + CNT_ONE);
`ifdef AXI_ARB_FIXED_PRIO_EN
      pick_m1   = m1_AWVALID & ~m0_AWVALID;
`else
      pick_m1   = m1_AWVALID & (~m0_AWVALID | ~last_grnt);
`endif
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         m0_wgrnt  <= 1'b0;
         m1_wgrnt  <= 1'b0;
         wr_busy   <= 1'b0;
         wr_err    <= 1'b0;
         last_grnt <= 1'b1;
         beat_cnt  <= '0;
         len_q     <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_AWVALID || m1_AWVALID) begin
                  m0_wgrnt <= ~pick_m1;
                  m1_wgrnt <= pick_m1;
                  wr_busy  <= 1'b1;
                  state    <= DATA;
               end
            end
            DATA: begin
               beat_cnt <= cnt_next;
               if (aw_hs) begin
                  aw_done <= 1'b1;
                  len_q   <= awlen;
               end
               if (w_hs && wlast) begin
                  w_done <= 1'b1;
               end
               // The beat check must use this cycle's count and length, since either may land now.
               if (aw_set && w_set) begin
                  state <= RESP;
                  if (cnt_next != exp_beats) begin
                     wr_err <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (b_hs) begin
                  last_grnt <= m1_wgrnt;
                  m0_wgrnt  <= 1'b0;
                  m1_wgrnt  <= 1'b0;
                  wr_busy   <= 1'b0;
                  beat_cnt  <= '0;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               m0_wgrnt <= 1'b0;
               m1_wgrnt <= 1'b0;
               wr_busy  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_arbiter_w.sv
// Directed self-checking bench for axi_master_arbiter_w; expected winners follow a local last-grant model.
module tb_axi_master_arbiter_w;

`ifdef AXI_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       ACLK = 1'b0;
   logic       ARESETn = 1'b0;
   logic       m0_AWVALID = 1'b0;
   logic       m1_AWVALID = 1'b0;
   logic       awvalid = 1'b0;
   logic       awready = 1'b0;
   logic [7:0] awlen = 8'd0;
   logic       wvalid = 1'b0;
   logic       wready = 1'b0;
   logic       wlast = 1'b0;
   logic       bvalid = 1'b0;
   logic       bready = 1'b0;
   logic       m0_wgrnt;
   logic       m1_wgrnt;
   logic       wr_busy;
   logic       wr_err;

   int   checks = 0;
   int   errors = 0;
   logic exp_last;
   logic exp_m1;

   axi_master_arbiter_w #(.LEN_BITS(8)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .m0_AWVALID (m0_AWVALID),
      .m1_AWVALID (m1_AWVALID),
      .awvalid    (awvalid),
      .awready    (awready),
      .awlen      (awlen),
      .wvalid     (wvalid),
      .wready     (wready),
      .wlast      (wlast),
      .bvalid     (bvalid),
      .bready     (bready),
      .m0_wgrnt   (m0_wgrnt),
      .m1_wgrnt   (m1_wgrnt),
      .wr_busy    (wr_busy),
      .wr_err     (wr_err)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   task automatic clear_hs;
      awvalid = 1'b0; awready = 1'b0; awlen = 8'd0;
      wvalid  = 1'b0; wready  = 1'b0; wlast = 1'b0;
      bvalid  = 1'b0; bready  = 1'b0;
   endtask

   task automatic test_reset;
      ARESETn = 1'b0;
      m0_AWVALID = 1'b0; m1_AWVALID = 1'b0;
      clear_hs();
      tick(); tick();
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_grants: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b00);
      end
      checks++;
      if ({wr_busy, wr_err} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_busy_err: got %b expected %b", {wr_busy, wr_err}, 2'b00);
      end
      ARESETn = 1'b1;
      tick();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy} !== 3'b000) begin
         errors++; $display("[TB] FAIL idle_no_req: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy}, 3'b000);
      end
      exp_last = 1'b1;
   endtask

   task automatic test_m0_only;
      m0_AWVALID = 1'b1;
      tick();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy} !== 3'b101) begin
         errors++; $display("[TB] FAIL m0_only_grant: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy}, 3'b101);
      end
      m0_AWVALID = 1'b0;
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd3;
      tick();
      clear_hs();
      for (int i = 1; i <= 4; i++) begin
         wvalid = 1'b1; wready = 1'b1; wlast = (i == 4);
         tick();
         checks++;
         if ({m0_wgrnt, m1_wgrnt} !== 2'b10) begin
            errors++; $display("[TB] FAIL m0_only_hold_beat%0d: got %b expected %b", i, {m0_wgrnt, m1_wgrnt}, 2'b10);
         end
      end
      clear_hs();
      checks++;
      if ({wr_busy, wr_err} !== 2'b10) begin
         errors++; $display("[TB] FAIL m0_only_resp: got %b expected %b", {wr_busy, wr_err}, 2'b10);
      end
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy, wr_err} !== 4'b0000) begin
         errors++; $display("[TB] FAIL m0_only_release: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy, wr_err}, 4'b0000);
      end
      exp_last = 1'b0;
      // Handshakes with no requester must leave the arbiter idle
      awvalid = 1'b1; awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy} !== 3'b000) begin
         errors++; $display("[TB] FAIL idle_ignore_hs: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy}, 3'b000);
      end
   endtask

   task automatic test_round_robin;
      m0_AWVALID = 1'b1; m1_AWVALID = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         exp_m1 = FIXED ? 1'b0 : ~exp_last;
         checks++;
         if ({m0_wgrnt, m1_wgrnt} !== {~exp_m1, exp_m1}) begin
            errors++; $display("[TB] FAIL rr_winner_%0d: got %b expected %b", t, {m0_wgrnt, m1_wgrnt}, {~exp_m1, exp_m1});
         end
         exp_last = exp_m1;
         awvalid = 1'b1; awready = 1'b1; awlen = 8'd0;
         wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
         tick();
         clear_hs();
         bvalid = 1'b1; bready = 1'b1;
         tick();
         clear_hs();
         checks++;
         if ({m0_wgrnt, m1_wgrnt, wr_busy} !== 3'b000) begin
            errors++; $display("[TB] FAIL rr_idle_gap_%0d: got %b expected %b", t, {m0_wgrnt, m1_wgrnt, wr_busy}, 3'b000);
         end
      end
      m0_AWVALID = 1'b0; m1_AWVALID = 1'b0;
      checks++;
      if (wr_err !== 1'b0) begin
         errors++; $display("[TB] FAIL rr_err: got %b expected %b", wr_err, 1'b0);
      end
   endtask

   task automatic test_w_before_aw;
      m1_AWVALID = 1'b1;
      tick();
      m1_AWVALID = 1'b0;
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b01) begin
         errors++; $display("[TB] FAIL wfirst_grant: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b01);
      end
      for (int i = 1; i <= 2; i++) begin
         wvalid = 1'b1; wready = 1'b1; wlast = (i == 2);
         tick();
      end
      clear_hs();
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy} !== 3'b011) begin
         errors++; $display("[TB] FAIL wfirst_b_in_data: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy}, 3'b011);
      end
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b01) begin
         errors++; $display("[TB] FAIL wfirst_hold: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b01);
      end
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy, wr_err} !== 4'b0000) begin
         errors++; $display("[TB] FAIL wfirst_done: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy, wr_err}, 4'b0000);
      end
      exp_last = 1'b1;
   endtask

   task automatic test_same_cycle;
      m0_AWVALID = 1'b1;
      tick();
      m0_AWVALID = 1'b0;
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b10) begin
         errors++; $display("[TB] FAIL same_grant: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b10);
      end
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd0;
      wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
      tick();
      clear_hs();
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, wr_busy, wr_err} !== 3'b000) begin
         errors++; $display("[TB] FAIL same_resp_next: got %b expected %b", {m0_wgrnt, wr_busy, wr_err}, 3'b000);
      end
      exp_last = 1'b0;
   endtask

   task automatic test_len_mismatch;
      m1_AWVALID = 1'b1;
      tick();
      m1_AWVALID = 1'b0;
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b01) begin
         errors++; $display("[TB] FAIL mis_grant: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b01);
      end
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd2;
      tick();
      clear_hs();
      wvalid = 1'b1; wready = 1'b1;
      tick();
      checks++;
      if (wr_err !== 1'b0) begin
         errors++; $display("[TB] FAIL mis_err_early: got %b expected %b", wr_err, 1'b0);
      end
      wlast = 1'b1;
      tick();
      clear_hs();
      checks++;
      if (wr_err !== 1'b1) begin
         errors++; $display("[TB] FAIL mis_err_set: got %b expected %b", wr_err, 1'b1);
      end
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m1_wgrnt, wr_err} !== 2'b01) begin
         errors++; $display("[TB] FAIL mis_release: got %b expected %b", {m1_wgrnt, wr_err}, 2'b01);
      end
      exp_last = 1'b1;
      m0_AWVALID = 1'b1;
      tick();
      m0_AWVALID = 1'b0;
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd0;
      wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
      tick();
      clear_hs();
      bvalid = 1'b1; bready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({wr_busy, wr_err} !== 2'b01) begin
         errors++; $display("[TB] FAIL mis_err_sticky: got %b expected %b", {wr_busy, wr_err}, 2'b01);
      end
      exp_last = 1'b0;
   endtask

   task automatic test_reset_mid;
      m0_AWVALID = 1'b1;
      tick();
      m0_AWVALID = 1'b0;
      awvalid = 1'b1; awready = 1'b1; awlen = 8'd3;
      tick();
      clear_hs();
      wvalid = 1'b1; wready = 1'b1;
      tick();
      clear_hs();
      checks++;
      if ({m0_wgrnt, wr_busy} !== 2'b11) begin
         errors++; $display("[TB] FAIL rmid_before: got %b expected %b", {m0_wgrnt, wr_busy}, 2'b11);
      end
      #2;
      ARESETn = 1'b0;
      #1;
      checks++;
      if ({m0_wgrnt, m1_wgrnt, wr_busy, wr_err} !== 4'b0000) begin
         errors++; $display("[TB] FAIL rmid_async: got %b expected %b", {m0_wgrnt, m1_wgrnt, wr_busy, wr_err}, 4'b0000);
      end
      ARESETn = 1'b1;
      exp_last = 1'b1;
      m0_AWVALID = 1'b1; m1_AWVALID = 1'b1;
      tick();
      m0_AWVALID = 1'b0; m1_AWVALID = 1'b0;
      checks++;
      if ({m0_wgrnt, m1_wgrnt} !== 2'b10) begin
         errors++; $display("[TB] FAIL rmid_first_tie: got %b expected %b", {m0_wgrnt, m1_wgrnt}, 2'b10);
      end
   endtask

   initial begin
      test_reset();
      test_m0_only();
      test_round_robin();
      test_w_before_aw();
      test_same_cycle();
      test_len_mismatch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_master_arbiter_w.md
Name: axi_master_arbiter_w

Overview:
- Two-master write-path arbiter for the interconnect, directly upstream of the AW/W/B muxes.
- Produces the one-hot m0_wgrnt/m1_wgrnt that steer those muxes.
- Holds each grant for one whole write transaction: AW handshake, all W beats through WLAST, then the B handshake.
- Round-robin between masters; checks the W beat count against AWLEN.

Parameters:
- LEN_BITS, 8, width of AWLEN; equals `LEN_BITS.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- m0_AWVALID  in  1  master 0 write-address request
- m1_AWVALID  in  1  master 1 write-address request
- awvalid  in  1  muxed AWVALID toward slave side
- awready  in  1  slave-side AWREADY
- awlen  in  LEN_BITS  muxed AWLEN
- wvalid  in  1  muxed WVALID
- wready  in  1  slave-side WREADY
- wlast  in  1  muxed WLAST
- bvalid  in  1  slave-side BVALID
- bready  in  1  muxed BREADY
- m0_wgrnt  out  1  grant to master 0, registered
- m1_wgrnt  out  1  grant to master 1, registered
- wr_busy  out  1  high whenever the state is not IDLE
- wr_err  out  1  sticky beat-count mismatch flag

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - Grants 2'b00.
  - wr_busy 0, wr_err 0.
  - last_grnt = master 1, so master 0 wins the first tie.
  - Beat counter 0; aw_done and w_done flags 0.
- Grants are always one-hot or zero, and change only on entry to or exit from IDLE.
- IDLE:
  - If either AWVALID is high, select a winner.
  - Only one requester: it wins.
  - Both requesting: the master not equal to last_grnt wins.
  - Register the winner's grant and go to DATA.
  - The grant is visible the cycle after the request is sampled, giving 1-cycle arbitration latency.
  - Neither requesting: stay in IDLE.
- DATA:
  - AW handshake (awvalid & awready) sets aw_done and captures awlen into len_q.
  - Each W handshake (wvalid & wready) increments the beat counter, saturating at 2^(LEN_BITS+1)-1.
  - A W handshake with wlast sets w_done.
  - W beats may precede the AW handshake; both orders are legal, and so are AW and WLAST in the same cycle.
  - Go to RESP in the cycle after both flags are set, or are being set in the current cycle.
  - On that transition, if the count including the current beat differs from len_q+1 (or awlen+1 if AW is captured this cycle), set wr_err. wr_err clears only on reset.
- RESP:
  - Hold the grant until bvalid & bready.
  - Then clear the grants, set last_grnt to the master just served, clear the counter and flags, and go to IDLE.
- Back-to-back transactions: there is one IDLE cycle between releasing a grant and issuing the next.
- A master dropping AWVALID after being granted does not revoke the grant; the arbiter waits for completion.
- Reset mid-transaction forces IDLE and zero grants immediately (asynchronous).
- Handshakes seen in IDLE, or in phases they do not belong to (e.g. B in DATA), are ignored.

Optional Feature:
- Macro: AXI_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins when both request; last_grnt is not used for selection.
- Undefined: round-robin as above.
- The macro changes nothing else.

Test Plan:
- Master 0 only: m0_AWVALID=1, then AW handshake with awlen=3, four W beats with wlast on beat 4, then B handshake.
  -> m0_wgrnt=1 from cycle 1 until the cycle after B; wr_err=0; returns to IDLE.
- Both masters request continuously, each transaction has awlen=0 and 1 beat.
  -> Grants alternate m0, m1, m0, m1 with one IDLE cycle between them.
  -> With AXI_ARB_FIXED_PRIO_EN defined: m0 every time.
- W before AW: master 1 sends two W beats (second with wlast), then AW with awlen=1, then B.
  -> Enters RESP after the AW handshake; wr_err=0; m1_wgrnt held throughout.
- Length mismatch: awlen=2 but wlast on beat 2.
  -> wr_err=1 after entering RESP and stays 1 through later correct transactions until reset.
- AW and WLAST in the same cycle with awlen=0.
  -> RESP next cycle; wr_err=0.
- Reset mid-transaction: assert ARESETn=0 during DATA.
  -> Grants drop to 0 without waiting for ACLK; after release, master 0 wins the first tie.
